// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared types and helpers for the sequential radix-2 Booth multiplier.
//   state_t     : controller states (IDLE, RUN)
//   booth_op_t  : action selected by the Booth pair {Q[0], q_1}
//   clog2       : elaboration-time ceiling log2 used to size counters
//   booth_decode: maps the Booth pair to an add/subtract/no-op action
// ---------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // Ceiling log2.
    // Callers pass N+1 so that the counter is wide enough to hold the value N.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Radix-2 Booth recoding.
    // The pair 10 starts a run of ones, so the multiplicand is subtracted.
    // The pair 01 ends a run of ones, so it is added back.
    // The pairs 00 and 11 sit inside a run of zeros or ones, so nothing happens.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b10:   op = SUB;
            2'b01:   op = ADD;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// ---------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration: conditional add/subtract of the
// multiplicand into the accumulator, then an arithmetic right shift of the
// whole {acc, q, q_1} chain by one bit.
//   Parameter N : extended operand width (accumulator and multiplicand are
//                 N+1 bits, the multiplier register is N bits)
//   acc_in      : accumulator before the step, N+1 bits
//   q_in        : multiplier/low-product register before the step, N bits
//   q_1_in      : Booth history bit before the step
//   m           : extended multiplicand, N+1 bits
//   acc_out     : accumulator after add/sub and shift
//   q_out       : multiplier register after shift
//   q_1_out     : history bit after shift (the old q_in[0])
// ---------------------------------------------------------------------------
module booth_step
    import booth_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N:0]   acc_in,
    input  logic [N-1:0] q_in,
    input  logic         q_1_in,
    input  logic [N:0]   m,
    output logic [N:0]   acc_out,
    output logic [N-1:0] q_out,
    output logic         q_1_out
);

    booth_op_t  op;
    logic [N:0] sum;

    // Pick the Booth action from the current pair and form the updated accumulator.
    // The accumulator is one bit wider than the extended operand.
    // Because of that guard bit, the subtraction cannot overflow.
    always_comb begin
        op  = booth_decode(q_in[0], q_1_in);
        sum = acc_in;
        case (op)
            ADD:     sum = acc_in + m;
            SUB:     sum = acc_in - m;
            default: sum = acc_in;
        endcase
    end

    // Arithmetic right shift of the concatenated {sum, q, q_1} chain.
    // The accumulator MSB is replicated to preserve the sign.
    assign acc_out = {sum[N], sum[N:1]};
    assign q_out   = {sum[0], q_in[N-1:1]};
    assign q_1_out = q_in[0];

endmodule

// File: rtl/booth_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_seq_mult
// Multi-cycle radix-2 Booth multiplier with configurable width, signed or
// unsigned operation and a start/busy/done handshake. One Booth step is done
// per clock; the product stays registered until the next operation finishes.
//   Parameter WIDTH : operand width, 2..32
//   clock           : rising-edge clock
//   reset_n         : synchronous active-low reset
//   start           : request pulse, accepted only while idle
//   signed_mode     : 1 = two's complement operands, 0 = unsigned
//   a, b            : multiplicand and multiplier, captured on accepted start
//   busy            : high while iterating
//   done            : one-cycle completion pulse; p valid from this cycle on
//   p               : 2*WIDTH product register
// ---------------------------------------------------------------------------
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int N  = WIDTH + 1;
    localparam int CW = clog2(N + 1);

    state_t       state;
    logic [CW-1:0] count;
    logic [N:0]   m_reg;
    logic [N:0]   acc;
    logic [N-1:0] q_reg;
    logic         q_1;

    logic [N:0]   a_ext;
    logic [N-1:0] b_ext;
    logic [N:0]   acc_next;
    logic [N-1:0] q_next;
    logic         q_1_next;

    // Widen the operands before capture.
    // In signed mode the sign bits are replicated; otherwise zeros are added.
    // The extra zero bit lets an unsigned operand behave as a positive
    // two's complement value. The Booth core can then always treat its
    // inputs as signed.
    // The multiplicand gets one more guard bit to match the accumulator width.
    always_comb begin
        a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        b_ext = signed_mode ? {b[WIDTH-1], b}      : {1'b0, b};
    end

    booth_step #(
        .N(N)
    ) u_step (
        .acc_in (acc),
        .q_in   (q_reg),
        .q_1_in (q_1),
        .m      (m_reg),
        .acc_out(acc_next),
        .q_out  (q_next),
        .q_1_out(q_1_next)
    );

    // Controller and datapath registers.
    // IDLE waits for start, then captures the operands and loads the
    // iteration count.
    // RUN commits one Booth step per edge.
    // The step that takes count from 1 to 0 is the last one. On that step
    // the low 2*WIDTH bits of the final {acc, q} are written to p and done
    // is pulsed.
    // A start that arrives during RUN is simply not looked at.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            count <= '0;
            m_reg <= '0;
            acc   <= '0;
            q_reg <= '0;
            q_1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= a_ext;
                        acc   <= '0;
                        q_reg <= b_ext;
                        q_1   <= 1'b0;
                        count <= CW'(N);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q_reg <= q_next;
                    q_1   <= q_1_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        p     <= {acc_next[2*WIDTH-N-1:0], q_next};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
